// File: rtl/maze_neighbor_probe_pkg.sv
// Shared definitions for the maze neighbour probe: default geometry,
// direction codes, FSM state encodings and the wall polarity.
// Optional feature macro: MAZE_PROBE_MARK_VISITED_EN (see maze_neighbor_probe.sv).
package maze_neighbor_probe_pkg;

  localparam int SIZE_DEF  = 16;
  localparam int ADR_W_DEF = 4;

  // A memory bit of 1 means the cell is a wall / blocked.
  localparam logic WALL = 1'b1;

  // Probe order is the numeric order of these codes.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_MARK   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Unsigned range test used for every bounds decision on coordinates.
  function automatic logic inRange(input int unsigned value, input int unsigned limit);
    return value < limit;
  endfunction

endpackage

// File: rtl/maze_neighbor_probe_if.sv
// Bundle of the probe request/response handshake and the maze memory pins.
// slave  : the probe itself (takes requests, drives the memory).
// master : the rat controller / memory side that talks to the probe.
interface maze_neighbor_probe_if
  import maze_neighbor_probe_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF
);

  logic             req;
  logic [ADR_W-1:0] curX;
  logic [ADR_W-1:0] curY;
  logic             busy;
  logic             done;
  logic [3:0]       wallMask;
  logic [ADR_W-1:0] adrX;
  logic [ADR_W-1:0] adrY;
  logic             read;
  logic             write;
  logic             memWrData;
  logic             memRdData;

  modport master (
    output req, curX, curY, memRdData,
    input  busy, done, wallMask, adrX, adrY, read, write, memWrData
  );

  modport slave (
    input  req, curX, curY, memRdData,
    output busy, done, wallMask, adrX, adrY, read, write, memWrData
  );

endinterface

// File: rtl/maze_neighbor_probe_addr.sv
// Neighbour address generator: given a cell and a direction, produce the
// neighbouring cell and whether it lies inside the SIZE x SIZE maze.
// A cell that is itself outside the maze never has an in-bounds neighbour,
// so no memory access can be derived from a bad request coordinate.
module maze_neighbor_probe_addr
  import maze_neighbor_probe_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int ADR_W = ADR_W_DEF
)
(
  input  logic [ADR_W-1:0] i_x,
  input  logic [ADR_W-1:0] i_y,
  input  dir_t             i_dir,
  output logic [ADR_W-1:0] o_nx,
  output logic [ADR_W-1:0] o_ny,
  output logic             o_inBounds
);

  logic w_cellOk;

  assign w_cellOk = inRange(32'(i_x), SIZE) && inRange(32'(i_y), SIZE);

  // Step one cell in the requested direction, refusing to cross any maze edge.
  always_comb begin
    o_nx       = i_x;
    o_ny       = i_y;
    o_inBounds = 1'b0;
    if (w_cellOk) begin
      case (i_dir)
        DIR_UP: begin
          if (i_y != '0) begin
            o_ny       = i_y - ADR_W'(1);
            o_inBounds = 1'b1;
          end
        end
        DIR_RIGHT: begin
          if (inRange(32'(i_x) + 32'd1, SIZE)) begin
            o_nx       = i_x + ADR_W'(1);
            o_inBounds = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (inRange(32'(i_y) + 32'd1, SIZE)) begin
            o_ny       = i_y + ADR_W'(1);
            o_inBounds = 1'b1;
          end
        end
        DIR_LEFT: begin
          if (i_x != '0) begin
            o_nx       = i_x - ADR_W'(1);
            o_inBounds = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/maze_neighbor_probe.sv
// Maze neighbour probe: reads the four neighbours of a cell from the maze
// memory (up, right, down, left) and returns a wall mask to the rat FSM.
// Each in-bounds direction takes an address setup cycle, a one-cycle read
// strobe and a sample cycle; an out-of-bounds direction is marked as a wall
// in a single cycle without touching memory.
// Optional feature macro: MAZE_PROBE_MARK_VISITED_EN -- when defined, the
// probed cell is written to 1 (visited/blocked) after the last direction.
module maze_neighbor_probe
  import maze_neighbor_probe_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int ADR_W = ADR_W_DEF
)
(
  input logic               clk,
  input logic               rst,
  maze_neighbor_probe_if.slave bus
);

  state_t           r_state;
  dir_t             r_dir;
  logic [ADR_W-1:0] r_x;
  logic [ADR_W-1:0] r_y;
  logic [ADR_W-1:0] r_adrX;
  logic [ADR_W-1:0] r_adrY;
  logic [3:0]       r_mask;
  logic             r_busy;
  logic             r_done;
  logic             r_read;

  logic [ADR_W-1:0] w_nx;
  logic [ADR_W-1:0] w_ny;
  logic             w_inBounds;
  logic             w_lastDir;
  dir_t             w_nextDir;
  state_t           w_finalState;

  maze_neighbor_probe_addr #(
    .SIZE  (SIZE),
    .ADR_W (ADR_W)
  ) u_addr (
    .i_x        (r_x),
    .i_y        (r_y),
    .i_dir      (r_dir),
    .o_nx       (w_nx),
    .o_ny       (w_ny),
    .o_inBounds (w_inBounds)
  );

  assign w_lastDir = (r_dir == DIR_LEFT);
  assign w_nextDir = dir_t'(r_dir + 2'd1);

`ifdef MAZE_PROBE_MARK_VISITED_EN
  logic r_write;
  logic r_memWrData;
  logic w_markOk;

  // Only mark a cell that actually exists in the maze.
  assign w_markOk     = inRange(32'(r_x), SIZE) && inRange(32'(r_y), SIZE);
  assign w_finalState = ST_MARK;
  assign bus.write     = r_write;
  assign bus.memWrData = r_memWrData;
`else
  assign w_finalState = ST_DONE;
  assign bus.write     = 1'b0;
  assign bus.memWrData = 1'b0;
`endif

  // Probe sequencer: latches the request, walks the four directions, and owns every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_x     <= '0;
      r_y     <= '0;
      r_adrX  <= '0;
      r_adrY  <= '0;
      r_mask  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_read  <= 1'b0;
`ifdef MAZE_PROBE_MARK_VISITED_EN
      r_write     <= 1'b0;
      r_memWrData <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (bus.req) begin
            r_x     <= bus.curX;
            r_y     <= bus.curY;
            r_dir   <= DIR_UP;
            r_mask  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_inBounds) begin
            r_adrX  <= w_nx;
            r_adrY  <= w_ny;
            r_state <= ST_STROBE;
          end else begin
            r_mask[r_dir] <= WALL;
            r_dir         <= w_nextDir;
            r_state       <= w_lastDir ? w_finalState : ST_SETUP;
          end
        end
        ST_STROBE: begin
          r_read  <= 1'b1;
          r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_read        <= 1'b0;
          r_mask[r_dir] <= bus.memRdData;
          r_dir         <= w_nextDir;
          r_state       <= w_lastDir ? w_finalState : ST_SETUP;
        end
`ifdef MAZE_PROBE_MARK_VISITED_EN
        ST_MARK: begin
          if (w_markOk) begin
            r_adrX      <= r_x;
            r_adrY      <= r_y;
            r_write     <= 1'b1;
            r_memWrData <= 1'b1;
          end
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: begin
`ifdef MAZE_PROBE_MARK_VISITED_EN
          r_write     <= 1'b0;
          r_memWrData <= 1'b0;
`endif
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.wallMask = r_mask;
  assign bus.adrX     = r_adrX;
  assign bus.adrY     = r_adrY;
  assign bus.read     = r_read;

endmodule
